// File: rtl/wb_port_arbiter.sv
// Purpose: owns the single register-file write port and arbitrates it between the pipeline writeback and a multi-cycle unit.
// Latency: the granted write appears on rfWe/rfAddr/rfData one cycle later.
// Backpressure: the MC unit waits via mcReady; after STARVE_LIMIT lost cycles the pipeline is stalled via pipeStall.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipeWrt,
    input  logic [4:0]  pipeRd,
    input  logic [31:0] pipeData,
    input  logic        mcValid,
    input  logic [4:0]  mcRd,
    input  logic [31:0] mcData,
    output logic        mcReady,
    output logic        pipeStall,
    output logic        rfWe,
    output logic [4:0]  rfAddr,
    output logic [31:0] rfData,
    output logic [7:0]  forcedCnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // 0 = idle, 1..LIMIT-1 = waiting, LIMIT = next MC request is forced through
    logic [3:0] waitCnt;
    logic       force_grant;
    logic       grant_mc;
    logic       grant_pipe;
    logic       mc_xfer;

    // Grant priority: forced MC, then pipeline, then opportunistic MC.
    // Outputs are gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        force_grant = 1'b0;
        grant_mc    = 1'b0;
        grant_pipe  = 1'b0;
        if (rst_n) begin
            force_grant = mcValid && (waitCnt == LIMIT);
            if (force_grant) begin
                grant_mc = 1'b1;
            end else if (pipeWrt) begin
                grant_pipe = 1'b1;
            end else if (mcValid) begin
                grant_mc = 1'b1;
            end
        end
    end

    assign mcReady   = grant_mc;
    assign pipeStall = force_grant;
    assign mc_xfer   = mcValid && grant_mc;

    // Starvation counter: grows while MC is refused, clears on transfer or withdrawal.
    // Forced grants always transfer, so the counter never passes LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= 4'd0;
        end else if (!mcValid || mc_xfer) begin
            waitCnt <= 4'd0;
        end else if (waitCnt != LIMIT) begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    // Register-file write port: one writer per cycle, address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfWe   <= 1'b0;
            rfAddr <= 5'd0;
            rfData <= 32'd0;
        end else if (grant_mc) begin
            rfWe   <= 1'b1;
            rfAddr <= mcRd;
            rfData <= mcData;
        end else if (grant_pipe) begin
            rfWe   <= 1'b1;
            rfAddr <= pipeRd;
            rfData <= pipeData;
        end else begin
            rfWe   <= 1'b0;
        end
    end

    // Saturating count of forced MC grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forcedCnt <= 8'd0;
        end else if (force_grant && (forcedCnt != 8'hFF)) begin
            forcedCnt <= forcedCnt + 8'd1;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, wait cycles a multi-cycle (MC) request tolerates before a forced grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pipeWrt  input  1  pipeline writeback request, from the EX/WB stage regWrt.
REQ-005 pipeRd  input  5  pipeline destination register.
REQ-006 pipeData  input  32  pipeline writeback data, already muxed by memToReg/svpc.
REQ-007 mcValid  input  1  MC unit has a result pending.
REQ-008 mcRd  input  5  MC destination register.
REQ-009 mcData  input  32  MC result data.
REQ-010 mcReady  output  1  combinational; MC result accepted this cycle.
REQ-011 pipeStall  output  1  combinational; pipeline must hold EX/WB and earlier stages this cycle.
REQ-012 rfWe  output  1  registered register-file write enable.
REQ-013 rfAddr  output  5  registered register-file write address.
REQ-014 rfData  output  32  registered register-file write data.
REQ-015 forcedCnt  output  8  registered saturating count of forced MC grants.

Function
REQ-016 The block shall own the single register-file write port and grant at most one writer per cycle.
REQ-017 Internal state shall be a 4-bit waitCnt: 0 = IDLE, 1..STARVE_LIMIT-1 = WAIT, STARVE_LIMIT = FORCE-eligible.
REQ-018 FORCE shall be (mcValid && waitCnt == STARVE_LIMIT); pipeStall = FORCE.
REQ-019 Grant: FORCE -> MC; else pipeWrt -> pipeline; else mcValid -> MC; else none.
REQ-020 mcReady shall equal (MC granted); an MC transfer occurs only when mcValid && mcReady.
REQ-021 mcValid, mcRd and mcData shall be held stable by the MC unit until transfer; the arbiter never buffers MC data.
REQ-022 In a FORCE cycle the pipeline request shall be ignored, not lost: the held EX/WB stage re-presents it next cycle.
REQ-023 Latency: the granted write shall appear on rfWe/rfAddr/rfData at the next posedge (1 cycle).
REQ-024 No grant: rfWe <= 0; rfAddr and rfData hold their previous values.
REQ-025 waitCnt: mcValid && !mcReady -> +1; MC transfer -> 0; !mcValid -> 0 (request withdrawn).
REQ-026 waitCnt shall never exceed STARVE_LIMIT, because FORCE always grants MC.
REQ-027 forcedCnt shall increment on each FORCE cycle and saturate at 255.
REQ-028 pipeRd == mcRd conflicts shall not be resolved here; writes land in grant order.

Reset
REQ-029 While rst_n = 0: waitCnt = 0, rfWe = 0, rfAddr = 0, rfData = 0, forcedCnt = 0.
REQ-030 While rst_n = 0, mcReady = 0 and pipeStall = 0 regardless of inputs.
REQ-031 Reset asserted mid-wait shall discard accumulated waitCnt; after release an MC request restarts from 0.

Verification
REQ-032 Reset: rst_n = 0 with all requests high -> all outputs 0 immediately, without a clock edge.
REQ-033 Pipeline only: pipeWrt = 1, pipeRd = 5, pipeData = 0xA5 -> next edge rfWe = 1, rfAddr = 5, rfData = 0xA5; mcReady = 0.
REQ-034 MC only: mcValid = 1, mcRd = 7, mcData = 0x1234, pipeWrt = 0 -> mcReady = 1 the same cycle; next edge rfAddr = 7, rfData = 0x1234.
REQ-035 Contention at STARVE_LIMIT = 4, pipeWrt and mcValid held high -> mcReady = 0 for cycles 1-4; cycle 5 pipeStall = 1 and mcReady = 1; next edge rfAddr = mcRd, forcedCnt = 1, waitCnt = 0; cycle 6 pipeline granted.
REQ-036 Reset pulse when waitCnt = 3 under contention -> after release, the forced grant occurs only after 4 further wait cycles.
REQ-037 Run 300 forced grants -> forcedCnt reads 255 and stays at 255.
